// File: rtl/change_dispenser_pkg.sv
// Shared types and helpers for the change dispenser.
// Contents: the FSM state enum, the Return_change code constants and the code-to-coin-count lookup.
package change_dispenser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GAP   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;
    localparam logic [1:0] CHG_15   = 2'b11;

    // Number of 5rs coins owed for one Return_change code
    function automatic logic [1:0] coin_count(input logic [1:0] code);
        logic [1:0] n;
        case (code)
            CHG_5:   n = 2'd1;
            CHG_10:  n = 2'd2;
            CHG_15:  n = 2'd3;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/change_dispenser_timer.sv
// dispense_timer: loadable down-counter with a done flag.
// The counter stops at zero; done is high whenever the count is zero.
module dispense_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load has priority over decrement; decrement saturates at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !done) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: queues 5rs coins owed for change and hands them to the hopper
// one at a time, with an idle gap after each coin and a FAULT state for an empty hopper.
// Optional feature: define CHANGE_TIMEOUT_EN to send a REQ that waits TIMEOUT_CYCLES
// without coin_ack to FAULT. Without it REQ waits indefinitely.
module change_dispenser #(
    parameter int unsigned MAX_PENDING    = 7,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Return_change,
    input  logic       coin_ack,
    input  logic       hopper_empty,
    input  logic       fault_clr,
    output logic       coin_req,
    output logic       busy,
    output logic [2:0] pending,
    output logic [7:0] coins_dispensed,
    output logic       overflow,
    output logic       fault
);

    import change_dispenser_pkg::*;

    // The timer counts to zero inclusive, so a window of N cycles loads N-1
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
`ifdef CHANGE_TIMEOUT_EN
    localparam int unsigned TO_LOAD  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int unsigned TMR_MAX  = (GAP_LOAD > TO_LOAD) ? GAP_LOAD : TO_LOAD;
`else
    localparam int unsigned TMR_MAX  = GAP_LOAD;
    // TIMEOUT_CYCLES stays on the interface so overrides remain legal; it drives no logic here
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif
    localparam int unsigned TMR_W    = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

    state_t           state;
    state_t           state_nx;
    logic             ack_acc;
    logic [3:0]       pend_sum;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_done;

    assign ack_acc = (state == ST_REQ) && coin_ack;

    // Owed-coin arithmetic: add and ack both apply in the same cycle
    always_comb begin
        pend_sum = {1'b0, pending} + {2'b00, coin_count(Return_change)} - {3'b000, ack_acc};
    end

    // Pending queue with saturation, sticky overflow and dispensed-coin counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending         <= '0;
            overflow        <= 1'b0;
            coins_dispensed <= '0;
        end else begin
            if (pend_sum > 4'(MAX_PENDING)) begin
                pending  <= 3'(MAX_PENDING);
                overflow <= 1'b1;
            end else begin
                pending  <= pend_sum[2:0];
            end
            if (ack_acc) begin
                coins_dispensed <= coins_dispensed + 8'd1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and timer control; the one timer serves both GAP and ack timeout
    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending != '0) begin
                    if (hopper_empty) begin
                        state_nx = ST_FAULT;
                    end else begin
                        state_nx = ST_REQ;
`ifdef CHANGE_TIMEOUT_EN
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(TO_LOAD);
`endif
                    end
                end
            end
            ST_REQ: begin
                if (coin_ack) begin
                    if (GAP_CYCLES == 0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(GAP_LOAD);
                    end
                end
`ifdef CHANGE_TIMEOUT_EN
                else if (tmr_done) begin
                    state_nx = ST_FAULT;
                end else begin
                    tmr_dec = 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (tmr_done) begin
                    state_nx = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !hopper_empty) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    dispense_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    assign coin_req = (state == ST_REQ);
    assign fault    = (state == ST_FAULT);
    assign busy     = (state != ST_IDLE) || (pending != '0);

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter MAX_PENDING, default 7: saturation limit of queued coins (fits in 3 bits).
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles enforced after each ejected coin.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum cycles `coin_req` may wait for `coin_ack` (used only under CHANGE_TIMEOUT_EN).
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
REQ-005 clk  input  1  Rising-edge clock.
REQ-006 reset  input  1  Asynchronous active-high reset.
REQ-007 Return_change  input  2  Change request from the vending FSM: 00 none, 01 = 5rs, 10 = 10rs, 11 = 15rs.
REQ-008 coin_ack  input  1  Hopper confirms that one 5rs coin was ejected.
REQ-009 hopper_empty  input  1  Hopper holds no coins.
REQ-010 fault_clr  input  1  Single-cycle pulse that clears FAULT.
REQ-011 coin_req  output  1  Request for the hopper to eject one 5rs coin.
REQ-012 busy  output  1  High while coins are pending or the FSM is not in IDLE.
REQ-013 pending  output  3  Number of coins still owed.
REQ-014 coins_dispensed  output  8  Running count of ejected coins; wraps from 255 to 0.
REQ-015 overflow  output  1  Sticky flag: a request was truncated by saturation.
REQ-016 fault  output  1  High while the FSM is in FAULT.

Function
REQ-017 Coin mapping: each cycle with nonzero Return_change adds 1, 2 or 3 coins to `pending` for codes 01, 10 and 11 respectively.
REQ-018 Cycle rule for `pending`: pending_next = pending + add − (ack accepted in REQ).
- When an add and an ack occur in the same cycle, both SHALL apply.
- pending_next saturates at MAX_PENDING; any saturation sets `overflow`.
REQ-019 States: IDLE, REQ, GAP, FAULT.
REQ-020 IDLE transitions:
- IDLE→REQ when pending≠0 and !hopper_empty.
- IDLE→FAULT when pending≠0 and hopper_empty.
REQ-021 REQ transitions: on coin_ack, the FSM decrements pending, increments coins_dispensed and goes to GAP. Otherwise it stays in REQ.
REQ-022 GAP: the FSM stays exactly GAP_CYCLES cycles, then goes to IDLE.
REQ-023 FAULT: the FSM goes to IDLE when fault_clr=1 and hopper_empty=0. pending is retained. Requests keep accumulating while in FAULT.
REQ-024 Output decode:
- coin_req = (state==REQ).
- fault = (state==FAULT).
- busy = (state≠IDLE) | (pending≠0).
- All outputs are registered or decoded from state, with no combinational path from inputs.
REQ-025 Latency: a code sampled at edge N gives pending updated after N. coin_req rises after edge N+1 when the hopper is available.
REQ-026 coin_ack outside REQ SHALL be ignored.
REQ-027 Minimum spacing between consecutive coin_req rising edges: 1 + GAP_CYCLES + 1 cycles.

Reset
REQ-028 Reset SHALL asynchronously force the following:
- state=IDLE
- pending=0
- coins_dispensed=0
- overflow=0
- gap/timeout counter=0
- all outputs low
REQ-029 Reset asserted mid-REQ SHALL drop coin_req immediately and discard owed coins.

Configuration
REQ-030 Macro CHANGE_TIMEOUT_EN controls the ack timeout.
- Defined: if coin_ack has not arrived after TIMEOUT_CYCLES cycles in REQ, the FSM goes to FAULT and pending is unchanged.
- Not defined: REQ waits indefinitely, and no timeout counter logic is synthesised.

Structure
REQ-031 Package change_dispenser_pkg holds:
- the state enum;
- Return_change code constants (CHG_NONE, CHG_5, CHG_10, CHG_15);
- the coin-count lookup function.
REQ-032 One sub-module, dispense_timer: a loadable down-counter with a done flag, shared between the GAP count and the timeout count.

Verification
REQ-033 Single 10rs code:
- Stimulus: Return_change=10 for 1 cycle; coin_ack returned 1 cycle after each coin_req.
- Response: exactly 2 coin_req pulses, each separated by ≥4 cycles; pending ends at 0; coins_dispensed=2; busy low afterwards.
REQ-034 Simultaneous add and ack:
- Stimulus: code 01 in the same cycle that coin_ack is accepted with pending=1.
- Response: pending stays 1, and one further coin is dispensed.
REQ-035 Saturation:
- Stimulus: codes 11, 11, 11 back-to-back from idle.
- Response: pending=7, overflow=1 and stays 1; exactly 7 coins are dispensed.
REQ-036 Empty hopper:
- Stimulus: code 01 with hopper_empty=1.
- Response: fault=1 and coin_req stays low.
- Then: with hopper_empty=0, a fault_clr pulse leads to one coin dispensed.
REQ-037 Timeout (with CHANGE_TIMEOUT_EN):
- Stimulus: code 01 and no coin_ack.
- Response: fault rises 16 cycles after coin_req rises; pending=1.
- Without the macro, coin_req stays high for ≥100 cycles.
REQ-038 Reset mid-operation:
- Stimulus: reset asserted while in REQ with pending=2.
- Response: coin_req low immediately; pending=0 and coins_dispensed=0 after reset.
